fei4_data_tx: RTL and testbench

- Transmit end of the FE-I4 style DOBOUT data link; the counterpart of the fei4_rx receive path.
- Pulls 24-bit data records from a first-word-fall-through FIFO and frames them with K-codes.
- 8b10b-encodes every symbol with running disparity and serializes one bit per CLK.
- Used as a readout-chip emulator on the test board and in the closed-loop bench against fei4_rx (CLK = 160 MHz bit clock).

---
 rtl/fei4_data_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_fei4_data_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fei4_data_tx.sv
// fei4_data_tx -- FE-I4 style DOBOUT transmitter.
// Pulls 24-bit records from a first-word-fall-through FIFO and frames them as
// K28.7, then three data bytes per record, then K28.1. K28.5 fills the line
// while idle. Every symbol is 8b10b-encoded with running disparity and sent
// one bit per CLK, bit 'a' first.
// Build option FEI4_DATA_TX_ERR_INJECT_EN adds the ERR_INJECT input. A rising
// edge on it forces a disparity error on the next D0 symbol.
module fei4_data_tx #(
  parameter int MAX_RECORDS = 16,
  parameter int IDLE_MIN    = 2
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY,
  input  logic [23:0] FIFO_DATA,
`ifdef FEI4_DATA_TX_ERR_INJECT_EN
  input  logic        ERR_INJECT,
`endif
  output logic        FIFO_READ,
  output logic        TX_DATA,
  output logic        SYMBOL_STROBE,
  output logic        BUSY
);

  localparam logic [7:0] MAX_REC  = 8'(MAX_RECORDS);
  localparam logic [3:0] IDLE_REQ = 4'(IDLE_MIN);
  localparam logic [7:0] K28_1    = 8'h3C;
  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K28_7    = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SOF, ST_D0, ST_D1, ST_D2, ST_EOF
  } state_t;

  // 5b/6b sub-block, RD- form (abcdei)
  function automatic logic [5:0] tbl_5b6b(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  // 3b/4b sub-block, RD- form (fghj), primary D.x.7
  function automatic logic [3:0] tbl_3b4b(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return 4'b1110;
    endcase
  endfunction

  // Returns {rd_out, abcdei, fghj}; rd = 1 means RD+.
  // Only K28.y control symbols are ever requested.
  function automatic logic [10:0] enc_8b10b(input logic is_k, input logic [7:0] sym,
                                            input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd_mid;
    logic       bal6;
    logic       alt7;
    x    = sym[4:0];
    y    = sym[7:5];
    bal6 = 1'b0;
    alt7 = 1'b0;
    if (is_k) begin
      c6     = rd_in ? 6'b110000 : 6'b001111;
      rd_mid = ~rd_in;
      case (y)
        3'd5:    c4 = 4'b1010;
        3'd7:    c4 = 4'b1000;
        default: c4 = 4'b1001;
      endcase
      if (!rd_mid) c4 = ~c4;
    end else begin
      c6   = tbl_5b6b(x);
      bal6 = ($countones(c6) == 3);
      // D.7 is balanced but still has a distinct RD+ form
      if (rd_in && x == 5'd7)   c6 = 6'b000111;
      else if (rd_in && !bal6)  c6 = ~c6;
      rd_mid = bal6 ? rd_in : ~rd_in;
      // Alternate D.x.A7 avoids a run of five equal bits across the boundary
      alt7 = (y == 3'd7) &&
             ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      c4 = alt7 ? 4'b0111 : tbl_3b4b(y);
      if (rd_mid && y == 3'd3)                   c4 = 4'b0011;
      else if (rd_mid && $countones(c4) != 2)    c4 = ~c4;
    end
    return {(($countones(c4) == 2) ? rd_mid : ~rd_mid), c6, c4};
  endfunction

  state_t      state_reg, state_next, eff_state;
  logic [3:0]  bit_cnt_reg;
  logic        rd_reg, rd_next;
  logic [7:0]  rec_cnt_reg, rec_cnt_next;
  logic [3:0]  idle_cnt_reg, idle_cnt_next;
  logic [15:0] hold_reg, hold_next;
  logic [8:0]  shift_reg;
  logic        tx_data_reg, fifo_read_reg, strobe_reg, busy_reg;
  logic        load, pop, sym_k, inject_now;
  logic [7:0]  sym_byte;
  logic [10:0] enc;

  assign load = (bit_cnt_reg == 4'd0);

  // Symbol selection and next-state decode, applied only at a symbol load.
  // A frame start is decided at the IDLE load itself so SOF goes out at the
  // very next symbol boundary instead of one idle symbol later.
  always_comb begin
    eff_state     = state_reg;
    state_next    = state_reg;
    rec_cnt_next  = rec_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    hold_next     = hold_reg;
    sym_k         = 1'b0;
    sym_byte      = 8'h00;
    pop           = 1'b0;
    if (state_reg == ST_IDLE && ENABLE && !FIFO_EMPTY && idle_cnt_reg >= IDLE_REQ)
      eff_state = ST_SOF;
    case (eff_state)
      ST_IDLE: begin
        sym_k    = 1'b1;
        sym_byte = K28_5;
        if (idle_cnt_reg != 4'd15) idle_cnt_next = idle_cnt_reg + 4'd1;
      end
      ST_SOF: begin
        sym_k      = 1'b1;
        sym_byte   = K28_7;
        state_next = ST_D0;
      end
      ST_D0: begin
        sym_byte     = FIFO_DATA[23:16];
        hold_next    = FIFO_DATA[15:0];
        pop          = 1'b1;
        rec_cnt_next = rec_cnt_reg + 8'd1;
        state_next   = ST_D1;
      end
      ST_D1: begin
        sym_byte   = hold_reg[15:8];
        state_next = ST_D2;
      end
      ST_D2: begin
        sym_byte   = hold_reg[7:0];
        state_next = (!FIFO_EMPTY && ENABLE && rec_cnt_reg < MAX_REC) ? ST_D0 : ST_EOF;
      end
      ST_EOF: begin
        sym_k         = 1'b1;
        sym_byte      = K28_1;
        rec_cnt_next  = 8'd0;
        idle_cnt_next = 4'd0;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // An injected symbol uses the code of the opposite disparity and leaves RD untouched
  assign enc     = enc_8b10b(sym_k, sym_byte, inject_now ? ~rd_reg : rd_reg);
  assign rd_next = inject_now ? rd_reg : enc[10];

`ifdef FEI4_DATA_TX_ERR_INJECT_EN
  logic err_in_d_reg, err_arm_reg;

  // Arm on an ERR_INJECT rising edge; disarm once the corrupted D0 is loaded
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      err_in_d_reg <= 1'b0;
      err_arm_reg  <= 1'b0;
    end else begin
      err_in_d_reg <= ERR_INJECT;
      if (ERR_INJECT && !err_in_d_reg) err_arm_reg <= 1'b1;
      else if (inject_now)             err_arm_reg <= 1'b0;
    end
  end

  assign inject_now = load && (eff_state == ST_D0) && err_arm_reg;
`else
  assign inject_now = 1'b0;
`endif

  // Bit counter, symbol load and serializer; outputs are all registered
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 4'd0;
      rd_reg        <= 1'b0;
      rec_cnt_reg   <= 8'd0;
      idle_cnt_reg  <= IDLE_REQ;
      hold_reg      <= 16'd0;
      shift_reg     <= 9'd0;
      tx_data_reg   <= 1'b0;
      fifo_read_reg <= 1'b0;
      strobe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      bit_cnt_reg   <= (bit_cnt_reg == 4'd9) ? 4'd0 : bit_cnt_reg + 4'd1;
      fifo_read_reg <= 1'b0;
      strobe_reg    <= 1'b0;
      if (load) begin
        state_reg     <= state_next;
        rd_reg        <= rd_next;
        rec_cnt_reg   <= rec_cnt_next;
        idle_cnt_reg  <= idle_cnt_next;
        hold_reg      <= hold_next;
        shift_reg     <= enc[8:0];
        tx_data_reg   <= enc[9];
        fifo_read_reg <= pop;
        strobe_reg    <= 1'b1;
        busy_reg      <= (eff_state != ST_IDLE);
      end else begin
        tx_data_reg <= shift_reg[8];
        shift_reg   <= {shift_reg[7:0], 1'b0};
      end
    end
  end

  assign TX_DATA       = tx_data_reg;
  assign FIFO_READ     = fifo_read_reg;
  assign SYMBOL_STROBE = strobe_reg;
  assign BUSY          = busy_reg;

endmodule

// File: tb/tb_fei4_data_tx.sv
// tb_fei4_data_tx -- directed bench for fei4_data_tx with default parameters.
// Expected symbol streams are hand-encoded 10-bit codes (abcdeifghj).
module tb_fei4_data_tx;

  logic        CLK = 1'b0;
  logic        RST_B = 1'b0;
  logic        ENABLE = 1'b0;
  logic        FIFO_EMPTY = 1'b1;
  logic [23:0] FIFO_DATA = 24'd0;
  logic        FIFO_READ, TX_DATA, SYMBOL_STROBE, BUSY;
`ifdef FEI4_DATA_TX_ERR_INJECT_EN
  logic        ERR_INJECT = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fei4_data_tx dut (
    .CLK           (CLK),
    .RST_B         (RST_B),
    .ENABLE        (ENABLE),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .FIFO_DATA     (FIFO_DATA),
`ifdef FEI4_DATA_TX_ERR_INJECT_EN
    .ERR_INJECT    (ERR_INJECT),
`endif
    .FIFO_READ     (FIFO_READ),
    .TX_DATA       (TX_DATA),
    .SYMBOL_STROBE (SYMBOL_STROBE),
    .BUSY          (BUSY)
  );

  typedef struct {
    logic [9:0] code;
    logic       busy;
  } sym_vec_t;

  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] K287_N = 10'b0011111000;
  localparam logic [9:0] K287_P = 10'b1100000111;
  localparam logic [9:0] K281_N = 10'b0011111001;
  localparam logic [9:0] K281_P = 10'b1100000110;

  logic [23:0] fifo_q[$];
  logic [9:0]  sym_q[$];
  logic        busy_q[$];
  int          reads = 0;
  int          frame_sizes[$];
  int          gap_sizes[$];

  // FIFO model and symbol monitor, all sampled on the falling edge
  initial begin
    logic [9:0] cur;
    logic       busy_cur;
    int         nbits;
    cur = 10'd0;
    busy_cur = 1'b0;
    nbits = 0;
    forever begin
      @(negedge CLK);
      if (FIFO_READ) begin
        reads++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      FIFO_EMPTY = (fifo_q.size() == 0);
      FIFO_DATA  = (fifo_q.size() == 0) ? 24'd0 : fifo_q[0];
      if (!RST_B) begin
        nbits = 0;
      end else if (SYMBOL_STROBE) begin
        cur = {9'd0, TX_DATA};
        busy_cur = BUSY;
        nbits = 1;
      end else if (nbits > 0 && nbits < 10) begin
        cur = {cur[8:0], TX_DATA};
        nbits++;
      end
      if (nbits == 10) begin
        sym_q.push_back(cur);
        busy_q.push_back(busy_cur);
        nbits = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_syms(input int n, input string name);
    int cyc = 0;
    while (sym_q.size() < n && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, " symbols seen"}, 32'(sym_q.size() >= n), 32'd1);
  endtask

  task automatic wait_reads(input int n, input string name);
    int cyc = 0;
    while (reads < n && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, " reads reached"}, 32'(reads >= n), 32'd1);
  endtask

  task automatic hold_reset();
    RST_B = 1'b0;
    ENABLE = 1'b1;
    fifo_q.delete();
    repeat (2) @(negedge CLK);
    sym_q.delete();
    busy_q.delete();
    reads = 0;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #2 RST_B = 1'b1;
  endtask

  function automatic bit is_k285(input logic [9:0] c);
    return (c == K285_N) || (c == K285_P);
  endfunction
  function automatic bit is_k287(input logic [9:0] c);
    return (c == K287_N) || (c == K287_P);
  endfunction
  function automatic bit is_k281(input logic [9:0] c);
    return (c == K281_N) || (c == K281_P);
  endfunction

  // Split the captured stream into frames: data symbols per frame, idles between frames
  task automatic analyze();
    int  data_n = 0;
    int  idle_n = 0;
    bit  in_frame = 0;
    bit  seen_frame = 0;
    frame_sizes.delete();
    gap_sizes.delete();
    foreach (sym_q[i]) begin
      if (is_k285(sym_q[i])) idle_n++;
      else if (is_k287(sym_q[i])) begin
        if (seen_frame) gap_sizes.push_back(idle_n);
        in_frame = 1;
        data_n = 0;
      end else if (is_k281(sym_q[i])) begin
        frame_sizes.push_back(data_n);
        in_frame = 0;
        seen_frame = 1;
        idle_n = 0;
      end else if (in_frame) data_n++;
    end
  endtask

  sym_vec_t vec_idle[6];
  sym_vec_t vec_one[8];
  sym_vec_t vec_two[11];

  initial begin
    // Idle stream after reset: K28.5 alternating RD- / RD+
    for (int i = 0; i < 6; i++) vec_idle[i] = '{(i % 2 == 0) ? K285_N : K285_P, 1'b0};
    // Record 0xA5C30F pushed during the first idle symbol
    vec_one[0] = '{K285_N, 1'b0};
    vec_one[1] = '{K285_P, 1'b0};
    vec_one[2] = '{K287_N, 1'b1};
    vec_one[3] = '{10'b1010011010, 1'b1};  // D5.5
    vec_one[4] = '{10'b1100010110, 1'b1};  // D3.6
    vec_one[5] = '{10'b0101110100, 1'b1};  // D15.0 RD-
    vec_one[6] = '{K281_N, 1'b1};
    vec_one[7] = '{K285_P, 1'b0};
    // Records 0xF1EB67, 0xF79C07: alternate D.x.7 both polarities, D.7 RD+, D.x.3
    vec_two[0]  = '{K285_N, 1'b0};
    vec_two[1]  = '{K285_P, 1'b0};
    vec_two[2]  = '{K287_N, 1'b1};
    vec_two[3]  = '{10'b1000110111, 1'b1};  // D17.7 RD- (A7)
    vec_two[4]  = '{10'b1101001000, 1'b1};  // D11.7 RD+ (A7)
    vec_two[5]  = '{10'b1110001100, 1'b1};  // D7.3 RD-
    vec_two[6]  = '{10'b1110100001, 1'b1};  // D23.7 RD- (P7)
    vec_two[7]  = '{10'b0011101101, 1'b1};  // D28.4 RD-
    vec_two[8]  = '{10'b0001110100, 1'b1};  // D7.0 RD+
    vec_two[9]  = '{K281_N, 1'b1};
    vec_two[10] = '{K285_P, 1'b0};

    // Reset values while held in reset
    hold_reset();
    check("rst TX_DATA", 32'(TX_DATA), 32'd0);
    check("rst FIFO_READ", 32'(FIFO_READ), 32'd0);
    check("rst SYMBOL_STROBE", 32'(SYMBOL_STROBE), 32'd0);
    check("rst BUSY", 32'(BUSY), 32'd0);

    // Empty FIFO: continuous K28.5, no pops
    release_reset();
    wait_syms(6, "idle");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("idle sym%0d code", i), 32'(sym_q[i]), 32'(vec_idle[i].code));
      check($sformatf("idle sym%0d busy", i), 32'(busy_q[i]), 32'(vec_idle[i].busy));
    end
    check("idle reads", 32'(reads), 32'd0);

    // One record
    hold_reset();
    release_reset();
    wait_syms(1, "one_rec start");
    fifo_q.push_back(24'hA5C30F);
    wait_syms(8, "one_rec");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("one_rec sym%0d code", i), 32'(sym_q[i]), 32'(vec_one[i].code));
      check($sformatf("one_rec sym%0d busy", i), 32'(busy_q[i]), 32'(vec_one[i].busy));
    end
    check("one_rec reads", 32'(reads), 32'd1);

    // Two back-to-back records
    hold_reset();
    release_reset();
    wait_syms(1, "two_rec start");
    fifo_q.push_back(24'hF1EB67);
    fifo_q.push_back(24'hF79C07);
    wait_syms(11, "two_rec");
    for (int i = 0; i < 11; i++) begin
      check($sformatf("two_rec sym%0d code", i), 32'(sym_q[i]), 32'(vec_two[i].code));
      check($sformatf("two_rec sym%0d busy", i), 32'(busy_q[i]), 32'(vec_two[i].busy));
    end
    check("two_rec reads", 32'(reads), 32'd2);

    // 40 records preloaded: frames of 16, 16, 8 with idle gaps
    hold_reset();
    for (int i = 0; i < 40; i++) fifo_q.push_back(24'(i * 24'h010203 + 24'h100000));
    release_reset();
    wait_syms(132, "max_rec");
    analyze();
    check("max_rec frames", 32'(frame_sizes.size()), 32'd3);
    check("max_rec frame0 data", 32'(frame_sizes.size() > 0 ? frame_sizes[0] : -1), 32'd48);
    check("max_rec frame1 data", 32'(frame_sizes.size() > 1 ? frame_sizes[1] : -1), 32'd48);
    check("max_rec frame2 data", 32'(frame_sizes.size() > 2 ? frame_sizes[2] : -1), 32'd24);
    check("max_rec gap0>=2", 32'(gap_sizes.size() > 0 && gap_sizes[0] >= 2), 32'd1);
    check("max_rec gap1>=2", 32'(gap_sizes.size() > 1 && gap_sizes[1] >= 2), 32'd1);
    check("max_rec reads", 32'(reads), 32'd40);

    // ENABLE dropped during D1 of record 3
    hold_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(24'h123456 + 24'(i));
    release_reset();
    wait_reads(3, "en_drop");
    repeat (12) @(negedge CLK);
    ENABLE = 1'b0;
    wait_syms(sym_q.size() + 20, "en_drop idle");
    analyze();
    check("en_drop frames", 32'(frame_sizes.size()), 32'd1);
    check("en_drop frame data", 32'(frame_sizes.size() > 0 ? frame_sizes[0] : -1), 32'd9);
    check("en_drop reads held", 32'(reads), 32'd3);
    ENABLE = 1'b1;
    wait_reads(6, "en_resume");
    check("en_resume reads", 32'(reads), 32'd6);

    // Asynchronous reset in the middle of D1
    hold_reset();
    fifo_q.push_back(24'hFFFFFF);
    fifo_q.push_back(24'hFFFFFF);
    release_reset();
    wait_reads(1, "mid_rst");
    repeat (12) @(negedge CLK);
    check("mid_rst busy before", 32'(BUSY), 32'd1);
    #2 RST_B = 1'b0;
    #1;
    check("mid_rst TX_DATA", 32'(TX_DATA), 32'd0);
    check("mid_rst BUSY", 32'(BUSY), 32'd0);
    check("mid_rst FIFO_READ", 32'(FIFO_READ), 32'd0);
    fifo_q.delete();
    sym_q.delete();
    busy_q.delete();
    release_reset();
    wait_syms(2, "mid_rst restart");
    check("mid_rst sym0", 32'(sym_q[0]), 32'(K285_N));
    check("mid_rst sym1", 32'(sym_q[1]), 32'(K285_P));

`ifdef FEI4_DATA_TX_ERR_INJECT_EN
    // Disparity error injected on D0 of record 0x000000
    hold_reset();
    release_reset();
    @(negedge CLK);
    ERR_INJECT = 1'b1;
    @(negedge CLK);
    ERR_INJECT = 1'b0;
    wait_syms(1, "inject start");
    fifo_q.push_back(24'h000000);
    wait_syms(7, "inject");
    check("inject sym2 sof", 32'(sym_q[2]), 32'(K287_N));
    check("inject sym3 d0", 32'(sym_q[3]), 32'(10'b0110001011));
    check("inject sym4 d1", 32'(sym_q[4]), 32'(10'b1001110100));
    check("inject sym5 d2", 32'(sym_q[5]), 32'(10'b1001110100));
    check("inject sym6 eof", 32'(sym_q[6]), 32'(K281_N));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
